// File: rtl/sdr_ref_timer_pkg.sv
// Shared SDRAM controller constants and refresh-timer types.
package sdr_parameters;

  localparam int NUM_CLK_REF_INTERVAL = 780;
  localparam int REF_MAX_PENDING      = 8;
  localparam int REF_URGENT_THRESH    = 4;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_REQ   = 2'd1,
    R_ACKED = 2'd2
  } ref_state_t;

endpackage

// File: rtl/sdr_ref_interval_cnt.sv
// Refresh interval counter: wraps every INTERVAL enabled cycles and emits
// a one-cycle tick in the cycle after the wrap.
module sdr_ref_interval_cnt
  import sdr_parameters::*;
#(
  parameter int INTERVAL = NUM_CLK_REF_INTERVAL,
  parameter int CNT_W    = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERVAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    tick_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else begin
      tick_d = wrap_q;
      if (en_i) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/sdr_ref_timer.sv
// Auto-refresh request generator: tracks owed refreshes and hands them one
// at a time to the command FSM via a req/ack handshake.
module sdr_ref_timer
  import sdr_parameters::*;
#(
  parameter int REF_INTERVAL_CLK = NUM_CLK_REF_INTERVAL,
  parameter int CNT_W            = 16,
  parameter int MAX_PENDING      = REF_MAX_PENDING,
  parameter int URGENT_THRESH    = REF_URGENT_THRESH
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       init_done,
  input  logic       ref_en,
  input  logic       ref_ack,
  output logic       ref_req,
  output logic       ref_urgent,
  output logic [3:0] pending_cnt,
  output logic       ref_overflow,
  output logic       ref_tick
);

  localparam logic [3:0] PEND_MAX = 4'(MAX_PENDING);
  localparam logic [3:0] PEND_URG = 4'(URGENT_THRESH);

  ref_state_t state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic       ovf_q, ovf_d;
  logic       ack_q;
  logic       req_q;
  logic       urgent_q;
  logic       tick;
  logic       ack_rise;
  logic       accept;

  sdr_ref_interval_cnt #(
    .INTERVAL (REF_INTERVAL_CLK),
    .CNT_W    (CNT_W)
  ) u_interval_cnt (
    .clk_i  (pclk),
    .rst_i  (preset),
    .clr_i  (~init_done),
    .en_i   (ref_en),
    .tick_o (tick)
  );

  // Only a fresh ack edge while a request is outstanding retires a refresh.
  assign ack_rise = ref_ack & ~ack_q;
  assign accept   = ack_rise & (state_q == R_REQ);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    if (!init_done) begin
      pending_d = 4'd0;
      state_d   = R_IDLE;
    end else begin
      if (tick && !accept) begin
        if (pending_q == PEND_MAX) begin
          ovf_d = 1'b1;
        end else begin
          pending_d = pending_q + 4'd1;
        end
      end else if (accept && !tick) begin
        if (pending_q != 4'd0) begin
          pending_d = pending_q - 4'd1;
        end else begin
          pending_d = pending_q;
        end
      end else begin
        pending_d = pending_q;
      end

      case (state_q)
        R_IDLE: begin
          if (pending_d != 4'd0) state_d = R_REQ;
          else                   state_d = R_IDLE;
        end
        R_REQ: begin
          if (accept) state_d = R_ACKED;
          else        state_d = R_REQ;
        end
        // Hold off re-requesting until the previous grant's ack is released.
        R_ACKED: begin
          if (!ref_ack) state_d = (pending_d != 4'd0) ? R_REQ : R_IDLE;
          else          state_d = R_ACKED;
        end
        default: state_d = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= R_IDLE;
      pending_q <= 4'd0;
      ovf_q     <= 1'b0;
      ack_q     <= 1'b0;
      req_q     <= 1'b0;
      urgent_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      ack_q     <= ref_ack;
      req_q     <= (state_d == R_REQ);
      urgent_q  <= (pending_d >= PEND_URG);
    end
  end

  assign ref_req      = req_q;
  assign ref_urgent   = urgent_q;
  assign pending_cnt  = pending_q;
  assign ref_overflow = ovf_q;
  assign ref_tick     = tick;

endmodule

// File: tb/tb_sdr_ref_timer.sv
// Randomized bench for sdr_ref_timer against a cycle-level behavioural model.
module tb_sdr_ref_timer;

  localparam int INT  = 10;
  localparam int MAXP = 8;
  localparam int THR  = 4;

  logic       pclk = 1'b0;
  logic       preset, init_done, ref_en, ref_ack;
  logic       ref_req, ref_urgent, ref_overflow, ref_tick;
  logic [3:0] pending_cnt;

  int n_vec = 0;
  int n_bad = 0;

  // Model: interval position, tick pipeline, backlog, flags and handshake.
  int m_cnt, m_pend;
  bit m_wrap, m_tick, m_ovf, m_req, m_urg, m_wait, m_prev_ack;
  int ack_left;

  sdr_ref_timer #(
    .REF_INTERVAL_CLK (INT),
    .CNT_W            (16),
    .MAX_PENDING      (MAXP),
    .URGENT_THRESH    (THR)
  ) dut (
    .pclk         (pclk),
    .preset       (preset),
    .init_done    (init_done),
    .ref_en       (ref_en),
    .ref_ack      (ref_ack),
    .ref_req      (ref_req),
    .ref_urgent   (ref_urgent),
    .pending_cnt  (pending_cnt),
    .ref_overflow (ref_overflow),
    .ref_tick     (ref_tick)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step();
    bit rise, take;
    int newp;
    if (preset) begin
      m_cnt = 0; m_wrap = 0; m_tick = 0; m_pend = 0; m_ovf = 0;
      m_req = 0; m_urg = 0; m_wait = 0; m_prev_ack = 0;
    end else begin
      rise = ref_ack && !m_prev_ack;
      if (!init_done) begin
        m_pend = 0; m_req = 0; m_urg = 0; m_wait = 0;
        m_cnt = 0; m_wrap = 0; m_tick = 0;
      end else begin
        take = rise && m_req;
        newp = m_pend + (m_tick ? 1 : 0) - (take ? 1 : 0);
        if (newp > MAXP) begin
          newp  = MAXP;
          m_ovf = 1;
        end
        if (take) begin
          m_wait = 1;
          m_req  = 0;
        end else if (m_wait) begin
          if (!ref_ack) begin
            m_wait = 0;
            m_req  = (newp > 0);
          end else begin
            m_req = 0;
          end
        end else begin
          m_req = (newp > 0);
        end
        m_pend = newp;
        m_urg  = (newp >= THR);
        m_tick = m_wrap;
        m_wrap = 0;
        if (ref_en) begin
          if (m_cnt == INT - 1) begin
            m_cnt  = 0;
            m_wrap = 1;
          end else begin
            m_cnt++;
          end
        end
      end
      m_prev_ack = ref_ack;
    end
  endtask

  task automatic check_all();
    chk("ref_req",      16'(ref_req),      16'(m_req));
    chk("ref_urgent",   16'(ref_urgent),   16'(m_urg));
    chk("pending_cnt",  16'(pending_cnt),  16'(m_pend));
    chk("ref_overflow", 16'(ref_overflow), 16'(m_ovf));
    chk("ref_tick",     16'(ref_tick),     16'(m_tick));
  endtask

  task automatic cycle();
    @(posedge pclk);
    model_step();
    @(negedge pclk);
    check_all();
  endtask

  // Reactive command-FSM stand-in: answers requests with acks of random length.
  task automatic drive_ack(input int spurious_odds);
    if (ack_left > 0) begin
      ref_ack = 1'b1;
      ack_left--;
    end else begin
      ref_ack = 1'b0;
      if (m_req && $urandom_range(0, 3) == 0) ack_left = $urandom_range(1, 4);
      else if (!m_req && $urandom_range(0, spurious_odds) == 0) ack_left = $urandom_range(1, 2);
    end
  endtask

  task automatic do_reset();
    preset = 1'b1; init_done = 1'b0; ref_en = 1'b1; ref_ack = 1'b0; ack_left = 0;
    repeat (3) cycle();
    preset = 1'b0;
    repeat (2) cycle();
  endtask

  initial begin
    int lat;
    do_reset();
    chk("reset_req", 16'(ref_req), 16'd0);
    chk("reset_pend", 16'(pending_cnt), 16'd0);

    // First tick latency and backlog growth to saturation without acks.
    init_done = 1'b1;
    lat = 0;
    for (int i = 1; i <= 50; i++) begin
      cycle();
      if (ref_tick && lat == 0) lat = i;
    end
    chk("first_tick_lat", 16'(lat), 16'(INT + 1));
    chk("urgent_at_4", 16'(ref_urgent), 16'd1);
    repeat (80) cycle();
    chk("sat_pend", 16'(pending_cnt), 16'(MAXP));
    chk("ovf_set", 16'(ref_overflow), 16'd1);

    // Drain with acks; overflow must stay sticky.
    for (int i = 0; i < 200; i++) begin
      drive_ack(40);
      cycle();
    end
    chk("ovf_sticky", 16'(ref_overflow), 16'd1);

    // Random mix of enable, init drops, resets and ack behaviour.
    for (int i = 0; i < 3000; i++) begin
      preset = ($urandom_range(0, 299) == 0);
      if (init_done) init_done = ($urandom_range(0, 149) != 0);
      else           init_done = ($urandom_range(0, 7) == 0);
      ref_en = ($urandom_range(0, 9) != 0);
      drive_ack(30);
      if (preset) ack_left = 0;
      cycle();
    end

    // Reset while a request is outstanding with backlog 3.
    preset = 1'b0; ref_ack = 1'b0; ack_left = 0; ref_en = 1'b1;
    do_reset();
    init_done = 1'b1;
    repeat (32) cycle();
    chk("pre_rst_pend", 16'(pending_cnt), 16'd3);
    chk("pre_rst_req", 16'(ref_req), 16'd1);
    preset = 1'b1;
    cycle();
    chk("rst_req", 16'(ref_req), 16'd0);
    chk("rst_pend", 16'(pending_cnt), 16'd0);
    chk("rst_urg", 16'(ref_urgent), 16'd0);
    chk("rst_ovf", 16'(ref_overflow), 16'd0);

    // Dropping init_done clears the backlog and the request.
    preset = 1'b0;
    repeat (32) cycle();
    init_done = 1'b0;
    cycle();
    chk("init_drop_req", 16'(ref_req), 16'd0);
    chk("init_drop_pend", 16'(pending_cnt), 16'd0);
    chk("init_drop_urg", 16'(ref_urgent), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
